// File: rtl/corr_mac_sequencer.sv
// Time-shared TAPS-tap correlator: one DWxDW multiplier and one accumulator,
// sequenced IDLE -> MAC (TAPS cycles) -> OUT for every accepted sample.
module corr_mac_sequencer #(
    parameter int TAPS = 10,
    parameter int DW   = 4,
    parameter int ACCW = 12
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            coef_we,
    input  logic [3:0]      coef_addr,
    input  logic [DW-1:0]   coef_data,
    input  logic            in_valid,
    input  logic [DW-1:0]   in_data,
    output logic            in_ready,
    output logic            out_valid,
    output logic [ACCW-1:0] out_data,
    output logic            busy
);
    localparam int KW = $clog2(TAPS);

    typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

    state_t                  state, state_nx;
    logic [TAPS-1:0][DW-1:0] s_reg;
    logic [TAPS-1:0][DW-1:0] c_reg;
    logic [ACCW-1:0]         acc;
    logic [ACCW-1:0]         acc_nx;
    logic [KW-1:0]           k;
    logic [2*DW-1:0]         prod;
    logic                    accept;
    logic                    coef_ok;
    logic                    last_tap;

    // Handshake and status come from the state register only (reset gates in_ready).
    assign in_ready  = (state == IDLE) && !reset;
    assign out_valid = (state == OUT);
    assign busy      = (state != IDLE);

    assign accept   = in_valid && in_ready;
    assign coef_ok  = coef_we && (state == IDLE) && (32'(coef_addr) < TAPS);
    assign last_tap = (k == KW'(TAPS - 1));

    assign prod   = {{DW{1'b0}}, s_reg[k]} * {{DW{1'b0}}, c_reg[k]};
    assign acc_nx = acc + {{(ACCW - 2*DW){1'b0}}, prod};

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept)   state_nx = MAC;
            MAC:     if (last_tap) state_nx = OUT;
            OUT:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            s_reg    <= '0;
            c_reg    <= '0;
            acc      <= '0;
            k        <= '0;
            out_data <= '0;
        end else begin
            // A write in the accepting cycle lands before the first MAC read.
            if (coef_ok) c_reg[coef_addr[KW-1:0]] <= coef_data;
            case (state)
                IDLE: if (accept) begin
                    s_reg <= {s_reg[TAPS-2:0], in_data};
                    acc   <= '0;
                    k     <= '0;
                end
                MAC: begin
                    acc <= acc_nx;
                    k   <= k + 1'b1;
                    if (last_tap) out_data <= acc_nx;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_corr_mac_sequencer.sv
// Directed bench for corr_mac_sequencer: reset, impulse, illegal writes,
// write+accept overlap, reset mid-MAC, full scale, handshake timing.
module tb_corr_mac_sequencer;
    localparam int TAPS = 10;
    localparam int DW   = 4;
    localparam int ACCW = 12;

    logic            clock = 1'b0;
    logic            reset;
    logic            coef_we;
    logic [3:0]      coef_addr;
    logic [DW-1:0]   coef_data;
    logic            in_valid;
    logic [DW-1:0]   in_data;
    logic            in_ready;
    logic            out_valid;
    logic [ACCW-1:0] out_data;
    logic            busy;

    int checks   = 0;
    int failures = 0;

    corr_mac_sequencer #(.TAPS(TAPS), .DW(DW), .ACCW(ACCW)) dut (
        .clock(clock), .reset(reset),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .busy(busy)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Called and returns at a negedge.
    task automatic write_coef(input logic [3:0] a, input logic [DW-1:0] d);
        coef_we = 1'b1; coef_addr = a; coef_data = d;
        @(negedge clock);
        coef_we = 1'b0;
    endtask

    // Offer a sample, then watch every cycle until in_ready returns.
    task automatic do_sample(input string tag, input logic [DW-1:0] d, input int expv, input bit hold);
        int n, lo, ov_cnt, ov_at, bz_bad;
        logic [ACCW-1:0] od;
        in_valid = 1'b1; in_data = d; n = 0;
        while (!in_ready && n < 30) begin @(negedge clock); n++; end
        if (!in_ready) chk({tag, "_ready_timeout"}, 0, 1);
        @(posedge clock);
        n = 0; lo = 0; ov_cnt = 0; ov_at = 0; bz_bad = 0; od = '0;
        do begin
            @(negedge clock); n++;
            if (n == 1) begin coef_we = 1'b0; if (!hold) in_valid = 1'b0; end
            if (!in_ready) lo++;
            if (busy === in_ready) bz_bad++;
            if (out_valid) begin ov_cnt++; ov_at = n; od = out_data; end
        end while (!in_ready && n < 30);
        chk({tag, "_data"}, 32'(od), expv);
        chk({tag, "_ov_cnt"}, ov_cnt, 1);
        chk({tag, "_ov_cycle"}, ov_at, TAPS + 1);
        chk({tag, "_ready_low"}, lo, TAPS + 1);
        chk({tag, "_busy"}, bz_bad, 0);
    endtask

    initial begin
        int ov_seen;
        reset = 1'b1; coef_we = 1'b0; coef_addr = '0; coef_data = '0;
        in_valid = 1'b0; in_data = '0;
        repeat (3) @(negedge clock);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_out_data", out_data, 0);
        reset = 1'b0;
        @(negedge clock);
        chk("rel_in_ready", in_ready, 1);

        // Impulse against c[k]=k+1, in_valid held across the whole run
        for (int i = 0; i < TAPS; i++) write_coef(4'(i), DW'(i + 1));
        do_sample("imp0", 4'd1, 1, 1'b1);
        for (int i = 1; i < TAPS; i++) do_sample($sformatf("imp%0d", i), 4'd0, i + 1, 1'b1);
        do_sample("imp_tail", 4'd0, 0, 1'b0);

        // Write during MAC and out-of-range write must both be dropped
        in_valid = 1'b1; in_data = 4'd0;
        @(posedge clock);
        @(negedge clock);
        in_valid = 1'b0; coef_we = 1'b1; coef_addr = 4'd0; coef_data = 4'd7;
        @(negedge clock);
        coef_we = 1'b0;
        for (int i = 0; i < 20 && !in_ready; i++) @(negedge clock);
        chk("ill_idle_again", in_ready, 1);
        write_coef(4'd12, 4'd9);
        do_sample("ill_imp", 4'd1, 1, 1'b0);

        // Write and accept in the same IDLE cycle: s=[2,1,0..], c0=5,c1=2 -> 12
        coef_we = 1'b1; coef_addr = 4'd0; coef_data = 4'd5;
        do_sample("wr_acc", 4'd2, 12, 1'b0);

        // Reset on the 4th MAC cycle aborts without a strobe and clears coefficients
        in_valid = 1'b1; in_data = 4'd3;
        @(posedge clock);
        ov_seen = 0;
        @(negedge clock); in_valid = 1'b0; ov_seen += int'(out_valid);
        @(negedge clock); ov_seen += int'(out_valid);
        @(negedge clock); ov_seen += int'(out_valid);
        @(negedge clock); ov_seen += int'(out_valid);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin @(negedge clock); ov_seen += int'(out_valid); end
        chk("mid_rst_in_ready", in_ready, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_out_data", out_data, 0);
        reset = 1'b0;
        for (int i = 0; i < 15; i++) begin @(negedge clock); ov_seen += int'(out_valid); end
        chk("mid_rst_no_ov", ov_seen, 0);
        chk("mid_rst_ready", in_ready, 1);
        do_sample("mid_rst_imp", 4'd1, 0, 1'b0);

        // Clear the sample history, then full-scale: 225*i, ending at 2250
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        for (int i = 0; i < TAPS; i++) write_coef(4'(i), 4'd15);
        for (int i = 1; i <= TAPS; i++)
            do_sample($sformatf("full%0d", i), 4'd15, 225 * i, i < TAPS);
        chk("full_final", out_data, 12'h8CA);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
